// File: rtl/video_stream_gen.sv
// Video test-pattern source: frames of xRes x yRes pixels with VS/HS blanking, frame count and pattern modes.
// Latency: VS rises one edge after an accepted start; each pixel is registered one edge after its decision.
// Backpressure: hold freezes x/y and drops dOutEn while in PIX; dOut keeps the last pixel. Ignored elsewhere.
//
// Ports:
//   clka, rst               clock (rising edge), asynchronous active-high reset
//   start, abort, hold      begin sequence (IDLE only), synchronous stop, pixel backpressure
//   mode                    0 ramp, 1 colour bars, 2 checkerboard, 3 constant
//   xRes, yRes              active pixels per row / rows per frame (latched on start)
//   hBlank, vBlank          HS / VS high cycles, 0 behaves as 1 (latched on start)
//   numFrames, constVal     frames to emit (0 = endless), mode-3 pixel value (latched on start)
//   dOut, dOutEn            pixel data and valid
//   HS, VS, busy, done      row sync, frame sync, not idle, one-cycle end pulse
//   frameCnt                frames completed since start
module video_stream_gen #(
  parameter int CH_W     = 8,
  parameter int NUM_CH   = 3,
  parameter int RES_W    = 11,
  parameter int BLANK_W  = 8,
  parameter int FRM_W    = 8,
  parameter int BAR_LOG2 = 6,
  parameter int CHK_LOG2 = 5
) (
  input  logic                     clka,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     hold,
  input  logic [1:0]               mode,
  input  logic [RES_W-1:0]         xRes,
  input  logic [RES_W-1:0]         yRes,
  input  logic [BLANK_W-1:0]       hBlank,
  input  logic [BLANK_W-1:0]       vBlank,
  input  logic [FRM_W-1:0]         numFrames,
  input  logic [CH_W*NUM_CH-1:0]   constVal,
  output logic [CH_W*NUM_CH-1:0]   dOut,
  output logic                     dOutEn,
  output logic                     HS,
  output logic                     VS,
  output logic                     busy,
  output logic                     done,
  output logic [FRM_W-1:0]         frameCnt
);

  localparam int DATA_W = CH_W * NUM_CH;

  typedef enum logic [2:0] {IDLE, VSB, PIX, HSB, DONE} state_t;

  state_t             state;
  logic [RES_W-1:0]   x;
  logic [RES_W-1:0]   y;
  logic [BLANK_W-1:0] bcnt;

  // Configuration captured on an accepted start
  logic [1:0]         mode_l;
  logic [RES_W-1:0]   xres_l;
  logic [RES_W-1:0]   yres_l;
  logic [BLANK_W-1:0] hblank_l;
  logic [BLANK_W-1:0] vblank_l;
  logic [FRM_W-1:0]   nframes_l;
  logic [DATA_W-1:0]  const_l;

  // Blank counters count down to zero, so load length-1; a zero length acts as one cycle.
  logic [BLANK_W-1:0] hb_m1;
  logic [BLANK_W-1:0] vb_m1;
  logic [BLANK_W-1:0] vb_in_m1;
  logic [FRM_W-1:0]   frame_next;
  logic               last_x;
  logic               last_y;

  assign hb_m1      = (hblank_l == '0) ? '0 : hblank_l - 1'b1;
  assign vb_m1      = (vblank_l == '0) ? '0 : vblank_l - 1'b1;
  assign vb_in_m1   = (vBlank == '0)   ? '0 : vBlank - 1'b1;
  assign frame_next = frameCnt + 1'b1;
  assign last_x     = (x == xres_l - 1'b1);
  assign last_y     = (y == yres_l - 1'b1);

  // Pixel value for coordinate (px, py) in frame fc; channel 0 occupies the MSBs.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [RES_W-1:0]  px,
    input logic [RES_W-1:0]  py,
    input logic [FRM_W-1:0]  fc,
    input logic [DATA_W-1:0] cv
  );
    logic [DATA_W-1:0] p;
    logic [CH_W-1:0]   ramp;
    logic [2:0]        bar;
    logic              chk;
    p    = '0;
    ramp = CH_W'(32'(px) + 32'(py) + 32'(fc));
    bar  = px[BAR_LOG2+2:BAR_LOG2];
    chk  = px[CHK_LOG2] ^ py[CHK_LOG2];
    for (int i = 0; i < NUM_CH; i++) begin
      case (m)
        2'd0:    p[(NUM_CH-1-i)*CH_W +: CH_W] = ramp;
        2'd1:    p[(NUM_CH-1-i)*CH_W +: CH_W] = {CH_W{bar[2 - (i % 3)]}};
        2'd2:    p[(NUM_CH-1-i)*CH_W +: CH_W] = {CH_W{chk}};
        default: p[(NUM_CH-1-i)*CH_W +: CH_W] = cv[(NUM_CH-1-i)*CH_W +: CH_W];
      endcase
    end
    return p;
  endfunction

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      bcnt      <= '0;
      mode_l    <= '0;
      xres_l    <= '0;
      yres_l    <= '0;
      hblank_l  <= '0;
      vblank_l  <= '0;
      nframes_l <= '0;
      const_l   <= '0;
      dOut      <= '0;
      dOutEn    <= 1'b0;
      HS        <= 1'b0;
      VS        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frameCnt  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        // Abort overrides every transition and suppresses done
        state  <= IDLE;
        dOutEn <= 1'b0;
        HS     <= 1'b0;
        VS     <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && xRes != '0 && yRes != '0) begin
              mode_l    <= mode;
              xres_l    <= xRes;
              yres_l    <= yRes;
              hblank_l  <= hBlank;
              vblank_l  <= vBlank;
              nframes_l <= numFrames;
              const_l   <= constVal;
              frameCnt  <= '0;
              x         <= '0;
              y         <= '0;
              bcnt      <= vb_in_m1;
              VS        <= 1'b1;
              busy      <= 1'b1;
              state     <= VSB;
            end
          end
          VSB: begin
            if (bcnt == '0) begin
              // First pixel of the frame is issued on the same edge VS drops
              VS     <= 1'b0;
              dOutEn <= 1'b1;
              dOut   <= pattern(mode_l, '0, '0, frameCnt, const_l);
              x      <= '0;
              y      <= '0;
              state  <= PIX;
            end else begin
              bcnt <= bcnt - 1'b1;
            end
          end
          PIX: begin
            // x/y name the pixel currently on dOut; hold keeps it and drops valid
            if (hold) begin
              dOutEn <= 1'b0;
            end else if (last_x) begin
              dOutEn <= 1'b0;
              x      <= '0;
              if (!last_y) begin
                y     <= y + 1'b1;
                HS    <= 1'b1;
                bcnt  <= hb_m1;
                state <= HSB;
              end else begin
                y        <= '0;
                frameCnt <= frame_next;
                if (nframes_l != '0 && frame_next == nframes_l) begin
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  VS    <= 1'b1;
                  bcnt  <= vb_m1;
                  state <= VSB;
                end
              end
            end else begin
              x      <= x + 1'b1;
              dOutEn <= 1'b1;
              dOut   <= pattern(mode_l, x + 1'b1, y, frameCnt, const_l);
            end
          end
          HSB: begin
            if (bcnt == '0) begin
              HS     <= 1'b0;
              dOutEn <= 1'b1;
              dOut   <= pattern(mode_l, '0, y, frameCnt, const_l);
              state  <= PIX;
            end else begin
              bcnt <= bcnt - 1'b1;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            dOutEn <= 1'b0;
            HS     <= 1'b0;
            VS     <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
